// File: rtl/cnn_layer_accel_job_ctrl_if.sv
// Host-job, quad-handshake and fetch-engine signals of the multi-quad job sequencer.
// The controller takes the master view; the host, quads and fetch engine take the slave view.
interface cnn_layer_accel_job_ctrl_if #(
    parameter int unsigned NUM_QUADS   = 4,
    parameter int unsigned JOB_PARAM_W = 128
);
    localparam int unsigned QuadIdxW = (NUM_QUADS > 1) ? $clog2(NUM_QUADS) : 1;

    logic                   host_job_valid;
    logic                   host_job_ready;
    logic [JOB_PARAM_W-1:0] host_job_params;
    logic [NUM_QUADS-1:0]   host_job_mask;
    logic [NUM_QUADS-1:0]   job_start;
    logic [NUM_QUADS-1:0]   job_accept;
    logic [JOB_PARAM_W-1:0] job_parameters;
    logic [NUM_QUADS-1:0]   job_fetch_request;
    logic [NUM_QUADS-1:0]   job_fetch_ack;
    logic [NUM_QUADS-1:0]   job_fetch_complete;
    logic [NUM_QUADS-1:0]   job_complete;
    logic [NUM_QUADS-1:0]   job_complete_ack;
    logic                   fetch_start;
    logic [QuadIdxW-1:0]    fetch_quad;
    logic                   fetch_done;
    logic                   job_done;
    logic [15:0]            job_done_count;
    logic                   err_spurious;

    modport master (
        input  host_job_valid, host_job_params, host_job_mask, job_accept,
               job_fetch_request, job_complete, fetch_done,
        output host_job_ready, job_start, job_parameters, job_fetch_ack, job_fetch_complete,
               job_complete_ack, fetch_start, fetch_quad, job_done, job_done_count, err_spurious
    );

    modport slave (
        output host_job_valid, host_job_params, host_job_mask, job_accept,
               job_fetch_request, job_complete, fetch_done,
        input  host_job_ready, job_start, job_parameters, job_fetch_ack, job_fetch_complete,
               job_complete_ack, fetch_start, fetch_quad, job_done, job_done_count, err_spurious
    );
endinterface

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Multi-quad job sequencer: queues host jobs, starts masked quads, round-robin arbitrates
// their parameter fetches onto one fetch engine and reports job completion.
module cnn_layer_accel_job_ctrl #(
    parameter int unsigned NUM_QUADS      = 4,
    parameter int unsigned JOB_PARAM_W    = 128,
    parameter int unsigned JOB_FIFO_DEPTH = 4
) (
    input logic                        clk_if,
    input logic                        rst,
    cnn_layer_accel_job_ctrl_if.master bus_io
);
    localparam int unsigned QW = (NUM_QUADS > 1) ? $clog2(NUM_QUADS) : 1;
    localparam int unsigned AW = $clog2(JOB_FIFO_DEPTH);
    localparam int unsigned EW = NUM_QUADS + JOB_PARAM_W;
    localparam logic [AW:0]   PtrOne   = {{AW{1'b0}}, 1'b1};
    localparam logic [QW-1:0] LastQuad = QW'(NUM_QUADS - 1);

    typedef enum logic [1:0] {JIdle, JStart, JRun, JDone} job_state_e;
    typedef enum logic {FIdle, FWait} fetch_state_e;

    job_state_e   job_q, job_d;
    fetch_state_e fetch_q, fetch_d;

    logic [EW-1:0] fifo_mem_q [JOB_FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full, push, pop;

    logic [JOB_PARAM_W-1:0] params_q, params_d;
    logic [NUM_QUADS-1:0]   mask_q, mask_d;
    logic [NUM_QUADS-1:0]   accepted_q, accepted_d;
    logic [NUM_QUADS-1:0]   done_q, done_d;
    logic [NUM_QUADS-1:0]   job_start_q, job_start_d;
    logic [NUM_QUADS-1:0]   cmp_ack_q, cmp_ack_d;
    logic [NUM_QUADS-1:0]   cmp_hit;
    logic                   job_done_q, job_done_d;
    logic [15:0]            count_q, count_d;

    logic [NUM_QUADS-1:0]   eligible;
    logic [NUM_QUADS-1:0]   fetch_ack_q, fetch_ack_d;
    logic [NUM_QUADS-1:0]   fetch_cmp_q, fetch_cmp_d;
    logic                   fetch_start_q, fetch_start_d;
    logic [QW-1:0]          fquad_q, fquad_d;
    logic [QW-1:0]          rr_q, rr_d;
    logic [QW-1:0]          grant_idx;
    logic                   grant_found;
    int unsigned            cand;
    logic                   err_q, err_d;

    // Job queue
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = bus_io.host_job_valid && !fifo_full;
    assign pop        = (job_q == JIdle) && !fifo_empty;

    always_ff @(posedge clk_if) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= {bus_io.host_job_mask, bus_io.host_job_params};
        end
    end

    // Job FSM
    always_comb begin
        job_d       = job_q;
        params_d    = params_q;
        mask_d      = mask_q;
        done_d      = done_q;
        count_d     = count_q;
        job_start_d = '0;
        cmp_ack_d   = '0;
        cmp_hit     = '0;
        job_done_d  = 1'b0;
        // An accept only counts while its start request is actually being driven.
        accepted_d  = accepted_q | (bus_io.job_accept & job_start_q);
        unique case (job_q)
            JIdle: begin
                if (!fifo_empty) begin
                    {mask_d, params_d} = fifo_mem_q[rd_ptr_q[AW-1:0]];
                    job_d = JStart;
                end
            end
            JStart: begin
                if (mask_q == '0) begin
                    job_d = JDone;
                end else if ((accepted_q & mask_q) == mask_q) begin
                    job_d = JRun;
                end
                job_start_d = mask_q & ~accepted_d;
            end
            JRun: begin
                cmp_hit   = bus_io.job_complete & mask_q & ~done_q;
                cmp_ack_d = cmp_hit;
                done_d    = done_q | cmp_hit;
                if (((done_q & mask_q) == mask_q) && (fetch_q == FIdle)) begin
                    job_d = JDone;
                end
            end
            JDone: begin
                job_done_d = 1'b1;
                count_d    = count_q + 16'd1;
                accepted_d = '0;
                done_d     = '0;
                job_d      = JIdle;
            end
            default: job_d = JIdle;
        endcase
    end

    // Fetch arbiter: a quad whose fetch just completed sits out for one cycle.
    always_comb begin
        eligible = '0;
        if ((job_q == JStart) || (job_q == JRun)) begin
            eligible = bus_io.job_fetch_request & mask_q & accepted_q & ~done_q & ~fetch_cmp_q;
        end
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NUM_QUADS; k++) begin
            cand = (int'(rr_q) + k) % NUM_QUADS;
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = QW'(cand);
            end
        end
    end

    always_comb begin
        fetch_d       = fetch_q;
        fquad_d       = fquad_q;
        rr_d          = rr_q;
        fetch_ack_d   = '0;
        fetch_cmp_d   = '0;
        fetch_start_d = 1'b0;
        unique case (fetch_q)
            FIdle: begin
                if (grant_found) begin
                    fetch_ack_d[grant_idx] = 1'b1;
                    fetch_start_d          = 1'b1;
                    fquad_d                = grant_idx;
                    rr_d                   = (grant_idx == LastQuad) ? '0 : grant_idx + QW'(1);
                    fetch_d                = FWait;
                end
            end
            FWait: begin
                if (bus_io.fetch_done) begin
                    fetch_cmp_d[fquad_q] = 1'b1;
                    fetch_d              = FIdle;
                end
            end
            default: fetch_d = FIdle;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (|(bus_io.job_accept & ~job_start_q))                   err_d = 1'b1;
        if ((job_q == JIdle) && (|bus_io.job_complete))            err_d = 1'b1;
        if (|(bus_io.job_complete & ~mask_q))                      err_d = 1'b1;
        if (bus_io.fetch_done && (fetch_q == FIdle))               err_d = 1'b1;
        if (|(bus_io.job_fetch_request & ~accepted_q))             err_d = 1'b1;
    end

    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            job_q         <= JIdle;
            fetch_q       <= FIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            params_q      <= '0;
            mask_q        <= '0;
            accepted_q    <= '0;
            done_q        <= '0;
            job_start_q   <= '0;
            cmp_ack_q     <= '0;
            job_done_q    <= 1'b0;
            count_q       <= '0;
            fetch_ack_q   <= '0;
            fetch_cmp_q   <= '0;
            fetch_start_q <= 1'b0;
            fquad_q       <= '0;
            rr_q          <= '0;
            err_q         <= 1'b0;
        end else begin
            job_q         <= job_d;
            fetch_q       <= fetch_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            params_q      <= params_d;
            mask_q        <= mask_d;
            accepted_q    <= accepted_d;
            done_q        <= done_d;
            job_start_q   <= job_start_d;
            cmp_ack_q     <= cmp_ack_d;
            job_done_q    <= job_done_d;
            count_q       <= count_d;
            fetch_ack_q   <= fetch_ack_d;
            fetch_cmp_q   <= fetch_cmp_d;
            fetch_start_q <= fetch_start_d;
            fquad_q       <= fquad_d;
            rr_q          <= rr_d;
            err_q         <= err_d;
        end
    end

    assign bus_io.host_job_ready     = !fifo_full;
    assign bus_io.job_start          = job_start_q;
    assign bus_io.job_parameters     = params_q;
    assign bus_io.job_fetch_ack      = fetch_ack_q;
    assign bus_io.job_fetch_complete = fetch_cmp_q;
    assign bus_io.job_complete_ack   = cmp_ack_q;
    assign bus_io.fetch_start        = fetch_start_q;
    assign bus_io.fetch_quad         = fquad_q;
    assign bus_io.job_done           = job_done_q;
    assign bus_io.job_done_count     = count_q;
    assign bus_io.err_spurious       = err_q;

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Directed bench for the multi-quad job sequencer; outputs are sampled on the falling edge.
module tb_cnn_layer_accel_job_ctrl;
    localparam int unsigned NQ = 4;
    localparam int unsigned PW = 128;

    logic clk_if = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   fc_pulses = 0;

    always #5 clk_if = ~clk_if;

    cnn_layer_accel_job_ctrl_if #(.NUM_QUADS(NQ), .JOB_PARAM_W(PW)) bus ();

    cnn_layer_accel_job_ctrl #(
        .NUM_QUADS     (NQ),
        .JOB_PARAM_W   (PW),
        .JOB_FIFO_DEPTH(4)
    ) dut (
        .clk_if(clk_if),
        .rst   (rst),
        .bus_io(bus)
    );

    always @(negedge clk_if) fc_pulses <= fc_pulses + $countones(bus.job_fetch_complete);

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_if);
    endtask

    task automatic clear_inputs();
        bus.host_job_valid    = 1'b0;
        bus.host_job_params   = '0;
        bus.host_job_mask     = '0;
        bus.job_accept        = '0;
        bus.job_fetch_request = '0;
        bus.job_complete      = '0;
        bus.fetch_done        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic push(input logic [3:0] m, input logic [127:0] p);
        bus.host_job_valid  = 1'b1;
        bus.host_job_mask   = m;
        bus.host_job_params = p;
        step();
        bus.host_job_valid  = 1'b0;
    endtask

    task automatic wait_start(input logic [3:0] m, input string tag);
        int n = 0;
        while (bus.job_start == '0 && n < 20) begin
            step();
            n++;
        end
        chk(tag, bus.job_start, m);
    endtask

    task automatic accept_all(input logic [3:0] m);
        bus.job_accept = m;
        step();
        bus.job_accept = '0;
        chk("start_drop", bus.job_start, 4'b0000);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.job_done && n < 20) begin
            step();
            n++;
        end
        chk(tag, bus.job_done, 1'b1);
    endtask

    task automatic finish_job(input logic [3:0] m, input logic [15:0] cnt);
        int n = 0;
        bus.job_complete = m;
        step();
        while (bus.job_complete_ack == '0 && n < 10) begin
            step();
            n++;
        end
        chk("cmp_ack", bus.job_complete_ack, m);
        bus.job_complete = '0;
        step();
        chk("cmp_ack_once", bus.job_complete_ack, 4'b0000);
        wait_done("job_done");
        chk("done_count", bus.job_done_count, cnt);
        step();
        chk("job_done_pulse", bus.job_done, 1'b0);
    endtask

    // Expects the grant for quad q to be visible now; runs the fetch to completion.
    task automatic fetch_one(input int q);
        logic [3:0] oh;
        oh = 4'b0001 << q;
        chk("fetch_ack", bus.job_fetch_ack, oh);
        chk("fetch_start", bus.fetch_start, 1'b1);
        chk("fetch_quad", bus.fetch_quad, q[1:0]);
        bus.job_fetch_request[q] = 1'b0;
        repeat (4) step();
        chk("fetch_quad_held", bus.fetch_quad, q[1:0]);
        bus.fetch_done = 1'b1;
        step();
        bus.fetch_done = 1'b0;
        chk("fetch_cmp", bus.job_fetch_complete, oh);
        step();
    endtask

    initial begin
        logic       seen;
        int         base;
        int         n;
        logic [127:0] pa5;
        pa5 = {16{8'hA5}};

        // Reset state
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        chk("rst_job_start", bus.job_start, 4'b0000);
        chk("rst_count", bus.job_done_count, 16'd0);
        chk("rst_err", bus.err_spurious, 1'b0);
        chk("rst_params", bus.job_parameters, 128'd0);
        chk("rst_ready", bus.host_job_ready, 1'b1);
        rst = 1'b0;
        step();

        // Single job, mask 0101
        push(4'b0101, pa5);
        chk("t1_start_n", bus.job_start, 4'b0000);
        step();
        chk("t1_start_n1", bus.job_start, 4'b0000);
        chk("t1_params", bus.job_parameters, pa5);
        step();
        chk("t1_start_n2", bus.job_start, 4'b0101);
        step();
        step();
        chk("t1_start_held", bus.job_start, 4'b0101);
        accept_all(4'b0101);
        finish_job(4'b0101, 16'd1);
        chk("t1_params_stable", bus.job_parameters, pa5);
        chk("t1_err", bus.err_spurious, 1'b0);

        // Round-robin fetch arbitration
        do_reset();
        push(4'b1011, 128'h1234);
        wait_start(4'b1011, "t2_start");
        accept_all(4'b1011);
        base = fc_pulses;
        bus.job_fetch_request = 4'b1011;
        step();
        fetch_one(0);
        fetch_one(1);
        fetch_one(3);
        chk("t2_cmp_pulses", 32'(fc_pulses - base), 32'd3);
        chk("t2_no_grant", bus.job_fetch_ack, 4'b0000);
        bus.job_fetch_request[0] = 1'b1;
        step();
        fetch_one(0);
        finish_job(4'b1011, 16'd1);
        chk("t2_err", bus.err_spurious, 1'b0);

        // Queue full while the active job stalls in START
        do_reset();
        push(4'b0001, 128'h0);
        wait_start(4'b0001, "t3_start_x");
        for (int i = 1; i <= 4; i++) begin
            chk("t3_ready_before", bus.host_job_ready, 1'b1);
            bus.host_job_valid  = 1'b1;
            bus.host_job_mask   = 4'b0001;
            bus.host_job_params = 128'(i);
            step();
        end
        bus.host_job_params = 128'd5;
        chk("t3_full", bus.host_job_ready, 1'b0);
        step();
        chk("t3_full_held", bus.host_job_ready, 1'b0);
        bus.host_job_valid = 1'b0;
        accept_all(4'b0001);
        bus.job_complete = 4'b0001;
        n = 0;
        while (bus.job_complete_ack == '0 && n < 10) begin
            step();
            n++;
        end
        bus.job_complete = '0;
        wait_done("t3_done_x");
        chk("t3_ready_at_done", bus.host_job_ready, 1'b0);
        step();
        chk("t3_ready_after_pop", bus.host_job_ready, 1'b1);
        chk("t3_params_j1", bus.job_parameters, 128'd1);
        for (int i = 1; i <= 4; i++) begin
            wait_start(4'b0001, "t3_start_j");
            chk("t3_params_order", bus.job_parameters, 128'(i));
            accept_all(4'b0001);
            finish_job(4'b0001, 16'(1 + i));
        end
        seen = 1'b0;
        repeat (6) begin
            seen = seen | (|bus.job_start);
            step();
        end
        chk("t3_fifth_dropped", seen, 1'b0);

        // Mask 0 job then mask 1111 job
        do_reset();
        bus.host_job_valid  = 1'b1;
        bus.host_job_mask   = 4'b0000;
        bus.host_job_params = 128'h0;
        step();
        bus.host_job_mask   = 4'b1111;
        bus.host_job_params = 128'hBEEF;
        step();
        bus.host_job_valid  = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!bus.job_done && n < 20) begin
            seen = seen | (|bus.job_start);
            step();
            n++;
        end
        chk("t4_done0", bus.job_done, 1'b1);
        chk("t4_no_start", seen, 1'b0);
        chk("t4_count1", bus.job_done_count, 16'd1);
        wait_start(4'b1111, "t4_start2");
        chk("t4_params2", bus.job_parameters, 128'hBEEF);
        accept_all(4'b1111);
        finish_job(4'b1111, 16'd2);

        // Spurious events
        do_reset();
        chk("t5_err_clear", bus.err_spurious, 1'b0);
        bus.job_complete = 4'b0010;
        step();
        bus.job_complete = '0;
        chk("t5_err_cmp_idle", bus.err_spurious, 1'b1);
        chk("t5_no_ack", bus.job_complete_ack, 4'b0000);
        step();
        chk("t5_err_sticky", bus.err_spurious, 1'b1);
        do_reset();
        bus.fetch_done = 1'b1;
        step();
        bus.fetch_done = 1'b0;
        chk("t5_err_fdone", bus.err_spurious, 1'b1);
        chk("t5_no_fcmp", bus.job_fetch_complete, 4'b0000);
        repeat (3) step();
        chk("t5_err_sticky2", bus.err_spurious, 1'b1);
        do_reset();
        bus.job_accept = 4'b0100;
        step();
        bus.job_accept = '0;
        chk("t5_err_accept", bus.err_spurious, 1'b1);
        push(4'b0001, 128'h77);
        step();
        step();
        chk("t5_fsm_ok", bus.job_start, 4'b0001);

        // Reset while a fetch is outstanding with two jobs queued
        do_reset();
        push(4'b0000, 128'h0);
        wait_done("t6_pre_done");
        chk("t6_pre_count", bus.job_done_count, 16'd1);
        bus.host_job_valid = 1'b1;
        bus.host_job_mask  = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            bus.host_job_params = 128'hC0FFEE + 128'(i);
            step();
        end
        bus.host_job_valid = 1'b0;
        wait_start(4'b0010, "t6_start");
        accept_all(4'b0010);
        bus.job_fetch_request[1] = 1'b1;
        step();
        chk("t6_grant", bus.job_fetch_ack, 4'b0010);
        bus.job_fetch_request[1] = 1'b0;
        chk("t6_fquad", bus.fetch_quad, 2'd1);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_start", bus.job_start, 4'b0000);
        chk("t6_rst_fquad", bus.fetch_quad, 2'd0);
        chk("t6_rst_params", bus.job_parameters, 128'd0);
        chk("t6_rst_count", bus.job_done_count, 16'd0);
        chk("t6_rst_ack", bus.job_fetch_ack, 4'b0000);
        chk("t6_rst_done", bus.job_done, 1'b0);
        clear_inputs();
        step();
        rst = 1'b0;
        step();
        chk("t6_ready", bus.host_job_ready, 1'b1);
        chk("t6_count", bus.job_done_count, 16'd0);
        seen = 1'b0;
        repeat (5) begin
            seen = seen | (|bus.job_start);
            step();
        end
        chk("t6_no_start", seen, 1'b0);
        push(4'b0100, 128'h1);
        step();
        step();
        chk("t6_new_start", bus.job_start, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
